// File: rtl/mobo_mem_responder_if.sv
// Purpose: CPU<->board request/status bus for the memory responder.
// Signals:
//   mobo_ctrl  [0]=req, [1]=we, [2+:ADDR_W]=addr  (master -> slave)
//   mobo_wdata write data                          (master -> slave)
//   mobo_stat  [0]=ack, [1]=busy, [2]=err          (slave -> master)
//   mobo_rdata read data, valid while ack on reads (slave -> master)
interface mobo_mem_responder_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] mobo_ctrl;
  logic [WORD_WIDTH-1:0] mobo_wdata;
  logic [WORD_WIDTH-1:0] mobo_stat;
  logic [WORD_WIDTH-1:0] mobo_rdata;

  modport master (
    output mobo_ctrl,
    output mobo_wdata,
    input  mobo_stat,
    input  mobo_rdata
  );

  modport slave (
    input  mobo_ctrl,
    input  mobo_wdata,
    output mobo_stat,
    output mobo_rdata
  );
endinterface

// File: rtl/mobo_mem_responder.sv
// Purpose: board-side responder for CPU read/write requests. Latches a
// request, waits LATENCY cycles, accesses an internal word memory and
// answers with a 4-phase req/ack handshake.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of mobo_mem_responder_if (ctrl/wdata in, stat/rdata out)
// Status outputs are registered from the current state, so they trail the
// FSM by one edge: req sampled at E0 -> busy after E0+1..E0+LATENCY,
// ack after E0+LATENCY+1.
module mobo_mem_responder #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mobo_mem_responder_if.slave    bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t                r_state, w_state_n;
  logic [CNT_W-1:0]      r_cnt, w_cnt_n;
  logic                  r_we, w_we_n;
  logic [ADDR_W-1:0]     r_addr, w_addr_n;
  logic [WORD_WIDTH-1:0] r_wdata, w_wdata_n;
  logic                  r_ack, w_ack_n;
  logic                  r_busy, w_busy_n;
  logic                  r_err, w_err_n;
  logic                  r_acc_err, w_acc_err_n;
  logic [WORD_WIDTH-1:0] r_rdata, w_rdata_n;
  logic                  w_mem_we;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  // Live request fields; only meaningful in IDLE
  logic                  w_req, w_we_live;
  logic [ADDR_W-1:0]     w_addr_live;
  assign w_req       = bus.mobo_ctrl[0];
  assign w_we_live   = bus.mobo_ctrl[1];
  assign w_addr_live = bus.mobo_ctrl[2 +: ADDR_W];

  logic w_unused_ctrl;
  assign w_unused_ctrl = &{1'b0, bus.mobo_ctrl[WORD_WIDTH-1:ADDR_W+2]};

  // Access operands: live values when the access happens straight from
  // IDLE (LATENCY=0), latched values when it follows WAIT
  logic                  w_acc_we, w_acc_oob;
  logic [ADDR_W-1:0]     w_acc_addr;
  logic [WORD_WIDTH-1:0] w_acc_wdata;
  logic [IDX_W-1:0]      w_acc_idx;
  assign w_acc_we    = (r_state == ST_IDLE) ? w_we_live      : r_we;
  assign w_acc_addr  = (r_state == ST_IDLE) ? w_addr_live    : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? bus.mobo_wdata : r_wdata;
  assign w_acc_oob   = ({1'b0, w_acc_addr} >= DEPTH_C);
  assign w_acc_idx   = IDX_W'(w_acc_addr);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_acc_err <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_we      <= w_we_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_ack     <= w_ack_n;
      r_busy    <= w_busy_n;
      r_err     <= w_err_n;
      r_acc_err <= w_acc_err_n;
      r_rdata   <= w_rdata_n;
    end
  end

  // Memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_acc_idx] <= w_acc_wdata;
  end

  // Next-state, access and output logic
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_we_n      = r_we;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_ack_n     = 1'b0;
    w_busy_n    = 1'b0;
    w_err_n     = 1'b0;
    w_acc_err_n = r_acc_err;
    w_rdata_n   = r_rdata;
    w_mem_we    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_we_n    = w_we_live;
          w_addr_n  = w_addr_live;
          w_wdata_n = bus.mobo_wdata;
          w_cnt_n   = CNT_W'(LATENCY);
          w_state_n = (LATENCY == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Dropping req during the wait aborts with no memory access
        if (!w_req) begin
          w_state_n = ST_IDLE;
        end else begin
          w_busy_n = 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_n = ST_ACK;
          else                    w_cnt_n   = r_cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (!w_req) begin
          w_state_n = ST_IDLE;
        end else begin
          w_ack_n = 1'b1;
          w_err_n = r_acc_err;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // The access is performed on the edge that enters ACK
    if (r_state != ST_ACK && w_state_n == ST_ACK) begin
      w_acc_err_n = w_acc_oob;
      if (w_acc_oob)      w_rdata_n = '0;
      else if (w_acc_we)  w_mem_we  = 1'b1;
      else                w_rdata_n = r_mem[w_acc_idx];
    end
  end

  assign bus.mobo_stat  = {(WORD_WIDTH-3)'(0), r_err, r_busy, r_ack};
  assign bus.mobo_rdata = r_rdata;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Bench: dut0 has DEPTH=200/LATENCY=2, dut1 has DEPTH=256/LATENCY=0.
module tb_mobo_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mobo_mem_responder_if #(.WORD_WIDTH(32)) if0 ();
  mobo_mem_responder_if #(.WORD_WIDTH(32)) if1 ();

  mobo_mem_responder #(.WORD_WIDTH(32), .ADDR_W(8), .DEPTH(200), .LATENCY(2))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  mobo_mem_responder #(.WORD_WIDTH(32), .ADDR_W(8), .DEPTH(256), .LATENCY(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_mem [200];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] c;
    c = {22'b0, addr, we, req};
    if (sel) begin if1.mobo_ctrl = c; if1.mobo_wdata = wd; end
    else     begin if0.mobo_ctrl = c; if0.mobo_wdata = wd; end
  endtask

  function automatic logic [31:0] get_stat(input bit sel);
    return sel ? if1.mobo_stat : if0.mobo_stat;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? if1.mobo_rdata : if0.mobo_rdata;
  endfunction

  // Full handshake; lat = edges after the sampling edge until ack (-1 on timeout)
  task automatic txn(input bit sel, input logic we, input logic [7:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic [31:0] st, output int lat);
    drive(sel, 1'b1, we, addr, wd);
    lat = -1; rd = '0; st = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      st = get_stat(sel);
      if (st[0]) begin rd = get_rdata(sel); break; end
    end
    if (!st[0]) lat = -1;
    drive(sel, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(); tick();
    n_cmp++; if (if0.mobo_stat !== 32'h0) begin n_err++; $display("FAIL reset_stat0: got %h expected %h", if0.mobo_stat, 32'h0); end
    n_cmp++; if (if0.mobo_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata0: got %h expected %h", if0.mobo_rdata, 32'h0); end
    n_cmp++; if (if1.mobo_stat !== 32'h0) begin n_err++; $display("FAIL reset_stat1: got %h expected %h", if1.mobo_stat, 32'h0); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] rd, st;
    int lat, n_ok;
    n_ok = 0;
    for (int i = 0; i < 200; i++) begin
      exp_mem[i] = 32'hC0DE0000 | 32'(i);
      txn(0, 1'b1, 8'(i), exp_mem[i], rd, st, lat);
      if (lat == 3 && st == 32'h1) n_ok++;
    end
    n_cmp++; if (n_ok !== 200) begin n_err++; $display("FAIL fill_acks: got %0d expected %0d", n_ok, 200); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, st;
    int lat;
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h2; exp_seq[2] = 32'h2; exp_seq[3] = 32'h1;
    drive(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    for (int e = 0; e < 4; e++) begin
      tick();
      n_cmp++; if (if0.mobo_stat !== exp_seq[e]) begin n_err++; $display("FAIL wr_stat_E%0d: got %h expected %h", e, if0.mobo_stat, exp_seq[e]); end
    end
    exp_mem[16] = 32'hDEADBEEF;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    n_cmp++; if (if0.mobo_stat !== 32'h0) begin n_err++; $display("FAIL wr_ack_drop: got %h expected %h", if0.mobo_stat, 32'h0); end
    txn(0, 1'b0, 8'h10, 32'h0, rd, st, lat);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h expected %h", rd, 32'hDEADBEEF); end
    n_cmp++; if (st !== 32'h1) begin n_err++; $display("FAIL rd_stat: got %h expected %h", st, 32'h1); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d expected %0d", lat, 3); end
  endtask

  task automatic test_hold();
    logic [31:0] rd, st;
    int lat;
    drive(0, 1'b1, 1'b0, 8'h20, 32'h0);
    for (int e = 0; e < 4; e++) tick();
    n_cmp++; if (if0.mobo_stat !== 32'h1) begin n_err++; $display("FAIL hold_ack: got %h expected %h", if0.mobo_stat, 32'h1); end
    // Live ctrl fields change while req stays high; must be ignored
    drive(0, 1'b1, 1'b1, 8'h21, 32'h55555555);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (if0.mobo_stat !== 32'h1) begin n_err++; $display("FAIL hold_stat_c%0d: got %h expected %h", c, if0.mobo_stat, 32'h1); end
      n_cmp++; if (if0.mobo_rdata !== exp_mem[32]) begin n_err++; $display("FAIL hold_rdata_c%0d: got %h expected %h", c, if0.mobo_rdata, exp_mem[32]); end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    n_cmp++; if (if0.mobo_stat !== 32'h0) begin n_err++; $display("FAIL hold_drop: got %h expected %h", if0.mobo_stat, 32'h0); end
    txn(0, 1'b0, 8'h00, 32'h0, rd, st, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", lat, 3); end
    n_cmp++; if (rd !== exp_mem[0]) begin n_err++; $display("FAIL b2b_rdata: got %h expected %h", rd, exp_mem[0]); end
    txn(0, 1'b0, 8'h21, 32'h0, rd, st, lat);
    n_cmp++; if (rd !== exp_mem[33]) begin n_err++; $display("FAIL hold_nowrite: got %h expected %h", rd, exp_mem[33]); end
  endtask

  task automatic test_oob();
    logic [31:0] rd, st;
    int lat;
    txn(0, 1'b0, 8'd250, 32'h0, rd, st, lat);
    n_cmp++; if (st !== 32'h5) begin n_err++; $display("FAIL oob_rd_stat: got %h expected %h", st, 32'h5); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oob_rd_data: got %h expected %h", rd, 32'h0); end
    n_cmp++; if (if0.mobo_stat !== 32'h0) begin n_err++; $display("FAIL oob_err_clear: got %h expected %h", if0.mobo_stat, 32'h0); end
    txn(0, 1'b1, 8'd250, 32'hFFFFFFFF, rd, st, lat);
    n_cmp++; if (st !== 32'h5) begin n_err++; $display("FAIL oob_wr_stat: got %h expected %h", st, 32'h5); end
    txn(0, 1'b0, 8'd199, 32'h0, rd, st, lat);
    n_cmp++; if (st !== 32'h1) begin n_err++; $display("FAIL edge199_stat: got %h expected %h", st, 32'h1); end
    for (int a = 0; a < 200; a++) begin
      txn(0, 1'b0, 8'(a), 32'h0, rd, st, lat);
      n_cmp++; if (rd !== exp_mem[a]) begin n_err++; $display("FAIL scan_addr%0d: got %h expected %h", a, rd, exp_mem[a]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, st;
    int lat, n_ack;
    drive(0, 1'b1, 1'b1, 8'h03, 32'h00001234);
    tick(); tick();
    n_cmp++; if (if0.mobo_stat !== 32'h2) begin n_err++; $display("FAIL abort_busy: got %h expected %h", if0.mobo_stat, 32'h2); end
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    n_cmp++; if (if0.mobo_stat !== 32'h0) begin n_err++; $display("FAIL abort_busy_drop: got %h expected %h", if0.mobo_stat, 32'h0); end
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (if0.mobo_stat[0]) n_ack++; end
    n_cmp++; if (n_ack !== 0) begin n_err++; $display("FAIL abort_no_ack: got %0d expected %0d", n_ack, 0); end
    txn(0, 1'b0, 8'h03, 32'h0, rd, st, lat);
    n_cmp++; if (rd !== exp_mem[3]) begin n_err++; $display("FAIL abort_rdata: got %h expected %h", rd, exp_mem[3]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, st;
    int lat;
    drive(0, 1'b1, 1'b1, 8'h05, 32'hBAD0BAD0);
    tick(); tick();
    rst = 1'b1;
    #2;
    n_cmp++; if (if0.mobo_stat !== 32'h0) begin n_err++; $display("FAIL rstmid_stat: got %h expected %h", if0.mobo_stat, 32'h0); end
    n_cmp++; if (if0.mobo_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_rdata: got %h expected %h", if0.mobo_rdata, 32'h0); end
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    txn(0, 1'b0, 8'h05, 32'h0, rd, st, lat);
    n_cmp++; if (rd !== exp_mem[5]) begin n_err++; $display("FAIL rstmid_rdata_after: got %h expected %h", rd, exp_mem[5]); end
  endtask

  task automatic test_lat0();
    logic [31:0] rd, st;
    int lat;
    drive(1, 1'b1, 1'b1, 8'h07, 32'hCAFEF00D);
    tick();
    n_cmp++; if (if1.mobo_stat !== 32'h0) begin n_err++; $display("FAIL lat0_E0: got %h expected %h", if1.mobo_stat, 32'h0); end
    tick();
    n_cmp++; if (if1.mobo_stat !== 32'h1) begin n_err++; $display("FAIL lat0_ack: got %h expected %h", if1.mobo_stat, 32'h1); end
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    txn(1, 1'b0, 8'h07, 32'h0, rd, st, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL lat0_latency: got %0d expected %0d", lat, 1); end
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL lat0_rdata: got %h expected %h", rd, 32'hCAFEF00D); end
    txn(1, 1'b1, 8'hFF, 32'h0BADCAFE, rd, st, lat);
    n_cmp++; if (st !== 32'h1) begin n_err++; $display("FAIL lat0_top_addr: got %h expected %h", st, 32'h1); end
    txn(1, 1'b0, 8'hFF, 32'h0, rd, st, lat);
    n_cmp++; if (rd !== 32'h0BADCAFE) begin n_err++; $display("FAIL lat0_top_rdata: got %h expected %h", rd, 32'h0BADCAFE); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_hold();
    test_oob();
    test_abort();
    test_reset_mid();
    test_lat0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
